conv2d_stream: RTL

- Streaming KxK valid-mode convolution stage; sits directly upstream of max_pool and drives its pxl_in/valid.
- Consumes a raster-order 8-bit unsigned pixel stream (one pixel per accepted cycle) of a DIM x DIM frame.
- Emits 9-bit signed, rescaled, saturated results in raster order: (DIM-K+1)^2 outputs per frame.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/line_buffer.sv | 32 +++
 rtl/conv2d_stream.sv | 138 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared widths plus saturation and weight-extraction helpers
//               for the streaming convolution stage.
// Revision    : 1.0
// ============================================================================
package conv_pkg;

    localparam int PIXEL_W  = 8;
    localparam int OUT_W    = 9;
    localparam int MAX_WW   = 8;
    localparam int MAX_TAPS = 25;
    localparam int FLAT_MAX = MAX_WW * MAX_TAPS;
    localparam int OUT_MAX  = (2 ** (OUT_W - 1)) - 1;
    localparam int OUT_MIN  = -(2 ** (OUT_W - 1));

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [31:0] v);
        if (v > OUT_MAX)
            return OUT_W'(OUT_MAX);
        else if (v < OUT_MIN)
            return OUT_W'(OUT_MIN);
        else
            return v[OUT_W-1:0];
    endfunction

    // Weights narrower than MAX_WW are sign-extended from their own top bit.
    function automatic logic signed [MAX_WW-1:0] get_weight(
        input logic [FLAT_MAX-1:0] flat,
        input int                  idx,
        input int                  ww
    );
        logic [MAX_WW-1:0] w;
        w = '0;
        for (int b = 0; b < MAX_WW; b++)
            w[b] = (b < ww) ? flat[idx * ww + b] : flat[idx * ww + ww - 1];
        return signed'(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Enabled shift register; dout is the sample shifted in DEPTH
//               enables ago.
// Revision    : 1.0
// ============================================================================
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               en,
    input  logic [PIXEL_W-1:0] din,
    output logic [PIXEL_W-1:0] dout
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream
// Description : Streaming KxK valid-mode convolution with shift and
//               saturation; two-cycle launch-to-result latency.
// Revision    : 1.0
// ============================================================================
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DIM   = 16,
    parameter int K     = 3,
    parameter int WW    = 4,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [K*K*WW-1:0]    weights,
    input  logic [PIXEL_W-1:0]   pxl_in,
    input  logic                 in_valid,
    output logic [OUT_W-1:0]     conv_out,
    output logic                 valid
);

    localparam int TAPS  = K * K;
    localparam int SUM_W = PIXEL_W + 1 + WW + $clog2(TAPS);
    localparam int CW    = $clog2(DIM);

    logic [CW-1:0]       row;
    logic [CW-1:0]       col;
    logic [PIXEL_W-1:0]  lb_out  [K-1];
    logic [PIXEL_W-1:0]  new_col [K];
    logic [PIXEL_W-1:0]  s1_col  [K];
    logic                s1_shift;
    logic                s1_done;
    logic [PIXEL_W-1:0]  win     [K][K];
    logic                s2_done;
    logic [FLAT_MAX-1:0] w_flat;
    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] shifted;
    logic signed [OUT_W-1:0] sat_val;

    assign w_flat = FLAT_MAX'(weights);

    generate
        for (genvar g = 0; g < K - 1; g++) begin : g_lbuf
            if (g == 0) begin : g_first
                line_buffer #(.DEPTH(DIM)) u_lb (
                    .clk  (clk),
                    .en   (in_valid),
                    .din  (pxl_in),
                    .dout (lb_out[g])
                );
            end else begin : g_chain
                line_buffer #(.DEPTH(DIM)) u_lb (
                    .clk  (clk),
                    .en   (in_valid),
                    .din  (lb_out[g-1]),
                    .dout (lb_out[g])
                );
            end
            assign new_col[K-2-g] = lb_out[g];
        end
    endgenerate

    assign new_col[K-1] = pxl_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (in_valid) begin
            if (col == CW'(DIM - 1)) begin
                col <= '0;
                row <= (row == CW'(DIM - 1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage 1: capture the incoming column and whether it completes a window.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_shift <= 1'b0;
            s1_done  <= 1'b0;
            for (int i = 0; i < K; i++)
                s1_col[i] <= '0;
        end else begin
            s1_shift <= in_valid;
            s1_done  <= in_valid && (row >= CW'(K - 1)) && (col >= CW'(K - 1));
            if (in_valid)
                s1_col <= new_col;
        end
    end

    // Stage 2: window shifts left with the captured column entering on the right.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_done <= 1'b0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    win[i][j] <= '0;
        end else begin
            s2_done <= s1_done;
            if (s1_shift) begin
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++)
                        win[i][j] <= win[i][j+1];
                    win[i][K-1] <= s1_col[i];
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                acc = acc + signed'({{(SUM_W - PIXEL_W){1'b0}}, win[i][j]})
                          * SUM_W'(get_weight(w_flat, i * K + j, WW));
        shifted = acc >>> SHIFT;
        sat_val = saturate(32'(shifted));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conv_out <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= s2_done;
            if (s2_done)
                conv_out <= sat_val;
        end
    end

endmodule
`default_nettype wire
